// File: rtl/dds_seq_pkg.sv
// Shared types and constants for the DDS sequencer: state encoding, DDS register
// addresses, control bit positions and the buffer-length rounding helper.
package dds_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SRST,
    ST_LD_WAIT,
    ST_WR_T,
    ST_WR_D,
    ST_WR_A,
    ST_PAD,
    ST_ARM,
    ST_RUN,
    ST_STOP
  } state_t;

  localparam logic [31:0] ADDR_THETAS = 32'd1;
  localparam logic [31:0] ADDR_DELTAS = 32'd2;
  localparam logic [31:0] ADDR_AMPLS  = 32'd3;

  localparam int CTRL_RST  = 0;
  localparam int CTRL_STRT = 1;

  // Smallest supported length (2, 8, 16, ..., 512) that holds count tones.
  function automatic logic [15:0] round_len(input logic [15:0] count);
    logic [15:0] len;
    len = 16'd2;
    if (count > 16'd2) begin
      len = 16'd8;
      for (int i = 0; i < 6; i++) begin
        if (len < count) len = len << 1;
      end
    end
    return len;
  endfunction

endpackage

// File: rtl/dds_sample_timer.sv
// Sample-period timer: down-counter reloaded with period-1, strobes on terminal count.
module dds_sample_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] period,
  output logic        strobe
);

  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= period - 16'd1;
    end else if (en) begin
      cnt <= (cnt == 16'd0) ? period - 16'd1 : cnt - 16'd1;
    end
  end

  assign strobe = en && (cnt == 16'd0);

endmodule

// File: rtl/dds_seq_ctrl.sv
// Loads tone triplets into the DDS, pads the buffer, arms it and paces sample_en.
// Optional DDS_SEQ_SAMPLE_CNT_EN adds the o_sample_cnt strobe counter.
//
//   state   | meaning
//   IDLE    | waiting for i_start
//   SRST    | DDS soft reset pulse, clear tone count
//   LD_WAIT | ready for a tone beat
//   WR_T/D/A| write theta / delta / amplitude
//   PAD     | decide whether another zero tone is needed
//   ARM     | DDS start, load sample timer
//   RUN     | DDS running, sample strobes
//   STOP    | DDS soft reset pulse, back to IDLE
module dds_seq_ctrl
  import dds_seq_pkg::*;
#(
  parameter int SIG_WIDTH = 16,
  parameter int MAX_TONES = 512,
  parameter int MARGIN    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic [15:0]          i_clkdiv,
  input  logic                 i_tone_valid,
  output logic                 o_tone_ready,
  input  logic [SIG_WIDTH-1:0] i_tone_theta,
  input  logic [SIG_WIDTH-1:0] i_tone_delta,
  input  logic [SIG_WIDTH-1:0] i_tone_ampl,
  input  logic                 i_tone_last,
  output logic [31:0]          o_dds_addrs,
  output logic                 o_dds_write,
  output logic [31:0]          o_dds_ctrl_reg,
  output logic [31:0]          o_dds_thetas_reg,
  output logic [31:0]          o_dds_deltas_reg,
  output logic [31:0]          o_dds_ampls_reg,
  output logic [31:0]          o_dds_lngth_reg,
  output logic                 o_dds_sample_en,
  output logic                 o_busy,
  output logic                 o_running,
`ifdef DDS_SEQ_SAMPLE_CNT_EN
  output logic [31:0]          o_sample_cnt,
`endif
  output logic                 o_err
);

  localparam int CW = $clog2(MAX_TONES + 1);

  state_t               state, nxt;
  logic [CW-1:0]        count, cnt_inc;
  logic [15:0]          len_q, clkdiv_q, p_eff;
  logic [16:0]          min_p;
  logic [SIG_WIDTH-1:0] theta_q, delta_q, ampl_q;
  logic                 last_q, pad_q, err_q, clamp, sample_stb, wrap_done;

  assign cnt_inc   = count + CW'(1);
  assign wrap_done = last_q || (cnt_inc == CW'(MAX_TONES));
  assign min_p     = {1'b0, len_q} + 17'(MARGIN);
  assign clamp     = {1'b0, clkdiv_q} < min_p;
  assign p_eff     = clamp ? min_p[15:0] : clkdiv_q;

  always_comb begin
    nxt = state;
    if (state != ST_IDLE && i_stop) begin
      nxt = ST_STOP;
    end else begin
      case (state)
        ST_IDLE:    if (i_start) nxt = ST_SRST;
        ST_SRST:    nxt = ST_LD_WAIT;
        ST_LD_WAIT: if (i_tone_valid) nxt = ST_WR_T;
        ST_WR_T:    nxt = ST_WR_D;
        ST_WR_D:    nxt = ST_WR_A;
        ST_WR_A:    nxt = (pad_q || wrap_done) ? ST_PAD : ST_LD_WAIT;
        ST_PAD:     nxt = (16'(count) < len_q) ? ST_WR_T : ST_ARM;
        ST_ARM:     nxt = ST_RUN;
        ST_RUN:     nxt = ST_RUN;
        ST_STOP:    nxt = ST_IDLE;
        default:    nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      count    <= '0;
      len_q    <= '0;
      clkdiv_q <= '0;
      theta_q  <= '0;
      delta_q  <= '0;
      ampl_q   <= '0;
      last_q   <= 1'b0;
      pad_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        ST_IDLE: if (i_start && !i_stop) begin
          err_q    <= 1'b0;
          clkdiv_q <= i_clkdiv;
        end
        ST_SRST: begin
          count <= '0;
          len_q <= '0;
          pad_q <= 1'b0;
        end
        ST_LD_WAIT: if (o_tone_ready && i_tone_valid) begin
          theta_q <= i_tone_theta;
          delta_q <= i_tone_delta;
          ampl_q  <= i_tone_ampl;
          last_q  <= i_tone_last;
        end
        ST_WR_A: if (!i_stop) begin
          count <= cnt_inc;
          // Entering the pad phase: freeze the length and zero the triplet.
          if (!pad_q && wrap_done) begin
            len_q   <= round_len(16'(cnt_inc));
            pad_q   <= 1'b1;
            theta_q <= '0;
            delta_q <= '0;
            ampl_q  <= '0;
            if (!last_q) err_q <= 1'b1;
          end
        end
        ST_ARM: if (clamp && !i_stop) err_q <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    o_dds_write      = 1'b0;
    o_dds_addrs      = '0;
    o_dds_thetas_reg = '0;
    o_dds_deltas_reg = '0;
    o_dds_ampls_reg  = '0;
    o_dds_ctrl_reg   = '0;
    case (state)
      ST_SRST, ST_STOP: o_dds_ctrl_reg[CTRL_RST]  = 1'b1;
      ST_ARM, ST_RUN:   o_dds_ctrl_reg[CTRL_STRT] = 1'b1;
      ST_WR_T: begin
        o_dds_write      = 1'b1;
        o_dds_addrs      = ADDR_THETAS;
        o_dds_thetas_reg = 32'(theta_q);
      end
      ST_WR_D: begin
        o_dds_write      = 1'b1;
        o_dds_addrs      = ADDR_DELTAS;
        o_dds_deltas_reg = 32'(delta_q);
      end
      ST_WR_A: begin
        o_dds_write     = 1'b1;
        o_dds_addrs     = ADDR_AMPLS;
        o_dds_ampls_reg = 32'(ampl_q);
      end
      default: ;
    endcase
  end

  assign o_tone_ready    = (state == ST_LD_WAIT) && !i_stop;
  assign o_busy          = (state != ST_IDLE) && (state != ST_RUN);
  assign o_running       = (state == ST_RUN);
  assign o_err           = err_q;
  assign o_dds_lngth_reg = 32'(len_q);
  assign o_dds_sample_en = sample_stb;

  dds_sample_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == ST_ARM),
    .en     (state == ST_RUN),
    .period (p_eff),
    .strobe (sample_stb)
  );

`ifdef DDS_SEQ_SAMPLE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || state == ST_SRST) o_sample_cnt <= '0;
    else if (sample_stb && o_sample_cnt != 32'hFFFF_FFFF) o_sample_cnt <= o_sample_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_dds_seq_ctrl.sv
// Scoreboard bench for dds_seq_ctrl: stimulus queues expected writes/strobes, a monitor checks them.
module tb_dds_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stop, tone_valid, tone_last, tone_ready;
  logic [15:0] clkdiv, theta, delta, ampl;
  logic [31:0] addrs, ctrl, thetas, deltas, ampls, lngth;
  logic        write, sample_en, busy, running, err;
`ifdef DDS_SEQ_SAMPLE_CNT_EN
  logic [31:0] sample_cnt;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_stb[$];
  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dds_seq_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .i_start          (start),
    .i_stop           (stop),
    .i_clkdiv         (clkdiv),
    .i_tone_valid     (tone_valid),
    .o_tone_ready     (tone_ready),
    .i_tone_theta     (theta),
    .i_tone_delta     (delta),
    .i_tone_ampl      (ampl),
    .i_tone_last      (tone_last),
    .o_dds_addrs      (addrs),
    .o_dds_write      (write),
    .o_dds_ctrl_reg   (ctrl),
    .o_dds_thetas_reg (thetas),
    .o_dds_deltas_reg (deltas),
    .o_dds_ampls_reg  (ampls),
    .o_dds_lngth_reg  (lngth),
    .o_dds_sample_en  (sample_en),
    .o_busy           (busy),
    .o_running        (running),
`ifdef DDS_SEQ_SAMPLE_CNT_EN
    .o_sample_cnt     (sample_cnt),
`endif
    .o_err            (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input string what);
    tests++;
    fails++;
    $display("FAIL %s: got %s expected none (cycle %0d)", name, what, cyc);
  endtask

  // Monitor: every write and strobe must match the head of its queue.
  always @(negedge clk) begin : monitor
    wr_t e;
    logic [31:0] sel;
    if (!rst) begin
      if (write) begin
        if (exp_wr.size() == 0) begin
          flag("unexpected_write", $sformatf("addr %0d", addrs));
        end else begin
          e = exp_wr.pop_front();
          sel = (addrs == 32'd1) ? thetas : (addrs == 32'd2) ? deltas : ampls;
          chk("wr_addr", addrs, e.addr);
          chk("wr_data", sel, e.data);
          chk("ctrl_during_wr", ctrl, 32'd0);
        end
      end else begin
        chk("bus_zero_no_wr", addrs | thetas | deltas | ampls, 32'd0);
      end
      if (sample_en) begin
        if (exp_stb.size() == 0) flag("unexpected_strobe", "sample_en");
        else chk("strobe_cycle", cyc, exp_stb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = {16'd0, d};
    exp_wr.push_back(e);
  endtask

  task automatic push_pad(input int n);
    for (int i = 0; i < n; i++) begin
      push_wr(32'd1, 16'd0);
      push_wr(32'd2, 16'd0);
      push_wr(32'd3, 16'd0);
    end
  endtask

  // Present one beat until accepted; returns at the cycle after the handshake.
  task automatic offer(input logic [15:0] t, d, a, input logic l, input int nwr);
    bit got = 0;
    tone_valid = 1'b1;
    theta = t; delta = d; ampl = a; tone_last = l;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (tone_ready) begin
        got = 1;
        if (nwr > 0) push_wr(32'd1, t);
        if (nwr > 1) push_wr(32'd2, d);
        if (nwr > 2) push_wr(32'd3, a);
      end
      tick();
    end
    tone_valid = 1'b0;
    theta = 16'hDEAD; delta = 16'hBEEF; ampl = 16'hCAFE; tone_last = 1'b1;
    if (!got) flag("tone_accept_timeout", "timeout");
  endtask

  task automatic begin_seq(input logic [15:0] div);
    start = 1'b1;
    clkdiv = div;
    tick();
    start = 1'b0;
    clkdiv = 16'hFFFF;
    @(negedge clk);
    chk("srst_ctrl", ctrl, 32'h1);
    chk("srst_busy", {31'd0, busy}, 32'd1);
    chk("err_cleared", {31'd0, err}, 32'd0);
    tick();
    @(negedge clk);
    chk("ld_ctrl", ctrl, 32'h0);
    tick();
  endtask

  // Returns at the negedge of the first RUN cycle.
  task automatic wait_running(output int rc);
    bit seen = 0;
    rc = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (running) begin
        seen = 1;
        rc = cyc;
      end else begin
        tick();
      end
    end
    if (!seen) flag("run_timeout", "timeout");
    chk("run_ctrl", ctrl, 32'h2);
  endtask

  task automatic push_stb(input int rc, input int p, input int n);
    for (int i = 0; i < n; i++) exp_stb.push_back(rc + p - 1 + i * p);
  endtask

  task automatic wait_stb_done(input int budget);
    int k = 0;
    while (exp_stb.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    if (exp_stb.size() != 0) begin
      flag("strobe_timeout", "timeout");
      exp_stb.delete();
    end
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    @(negedge clk);
    chk("stop_ctrl", ctrl, 32'h1);
    chk("stop_sample_en", {31'd0, sample_en}, 32'd0);
    chk("stop_busy", {31'd0, busy}, 32'd1);
    tick();
    @(negedge clk);
    chk("idle_after_stop", {29'd0, busy, running, write}, 32'd0);
    chk("idle_ctrl", ctrl, 32'h0);
    tick();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_flags"}, {26'd0, write, tone_ready, busy, running, err, sample_en}, 32'd0);
    chk({name, "_ctrl"}, ctrl, 32'd0);
    chk({name, "_lngth"}, lngth, 32'd0);
    chk({name, "_addrs"}, addrs, 32'd0);
  endtask

  task automatic three_tone_run(input logic [15:0] div, input int nstb);
    int rc;
    begin_seq(div);
    for (int i = 0; i < 3; i++)
      offer(16'h1100 + 16'(i), 16'h2200 + 16'(i), 16'h3300 + 16'(i), i == 2, 3);
    push_pad(5);
    wait_running(rc);
    chk("len_3_tones", lngth, 32'd8);
    chk("err_3_tones", {31'd0, err}, 32'd0);
    push_stb(rc, int'(div), nstb);
    tick();
    wait_stb_done(int'(div) * (nstb + 1));
    chk("wr_drained", exp_wr.size(), 0);
  endtask

  initial begin
    int rc, ready_seen;
    rst = 1'b1; start = 1'b0; stop = 1'b0; clkdiv = '0;
    tone_valid = 1'b0; tone_last = 1'b0; theta = '0; delta = '0; ampl = '0;
    repeat (3) tick();
    @(negedge clk);
    chk_all_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    // Three tones, clkdiv 100: 9 writes, 15 pad writes, len 8, strobes every 100.
    three_tone_run(16'd100, 3);
    do_stop();

    // Single tone, clkdiv 3: len 2, period clamped to 6.
    begin_seq(16'd3);
    offer(16'hABCD, 16'h0123, 16'h7FFF, 1'b1, 3);
    push_pad(1);
    wait_running(rc);
    chk("len_1_tone", lngth, 32'd2);
    chk("err_clamp", {31'd0, err}, 32'd1);
    push_stb(rc, 6, 3);
    tick();
    wait_stb_done(40);
    do_stop();

    // Overflow: 512 accepted, the next beat is never taken.
    begin_seq(16'd1000);
    for (int i = 0; i < 512; i++)
      offer(16'(i), 16'(i * 3), 16'hFFFF - 16'(i), 1'b0, 3);
    tone_valid = 1'b1; tone_last = 1'b0;
    ready_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tone_ready) ready_seen++;
      tick();
    end
    tone_valid = 1'b0;
    chk("ovf_ready_after", ready_seen, 0);
    chk("ovf_err", {31'd0, err}, 32'd1);
    chk("ovf_len", lngth, 32'd512);
    chk("ovf_running", {31'd0, running}, 32'd1);
    chk("ovf_wr_drained", exp_wr.size(), 0);
    do_stop();

    // Stop during WR_D of the second tone.
    begin_seq(16'd50);
    offer(16'h0111, 16'h0222, 16'h0333, 1'b0, 3);
    offer(16'h0444, 16'h0555, 16'h0666, 1'b0, 2);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    @(negedge clk);
    chk("wrd_stop_ctrl", ctrl, 32'h1);
    tick();
    @(negedge clk);
    chk("wrd_stop_idle", {30'd0, busy, running}, 32'd0);
    tick();
    tone_valid = 1'b1;
    ready_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tone_ready) ready_seen++;
      tick();
    end
    tone_valid = 1'b0;
    chk("idle_no_ready", ready_seen, 0);
    chk("stop_wr_drained", exp_wr.size(), 0);

    // Valid toggled with 5-cycle gaps of junk data.
    begin_seq(16'd10);
    offer(16'h0A0A, 16'h0B0B, 16'h0C0C, 1'b0, 3);
    repeat (5) tick();
    offer(16'h0D0D, 16'h0E0E, 16'h0F0F, 1'b1, 3);
    wait_running(rc);
    chk("gap_len", lngth, 32'd2);
    chk("gap_err", {31'd0, err}, 32'd0);
    push_stb(rc, 10, 2);
    tick();
    wait_stb_done(40);
    chk("gap_wr_drained", exp_wr.size(), 0);
    do_stop();

    // Sync reset while running, then a clean replay.
    begin_seq(16'd20);
    for (int i = 0; i < 3; i++)
      offer(16'h1100 + 16'(i), 16'h2200 + 16'(i), 16'h3300 + 16'(i), i == 2, 3);
    push_pad(5);
    wait_running(rc);
    tick();
    repeat (5) tick();
    exp_stb.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("midrun_rst");
    tick();
    three_tone_run(16'd20, 2);
    do_stop();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

endmodule
